// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and width constants.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   localparam int unsigned DW_DEF = 16;
   localparam int unsigned VW_DEF = 8;
   localparam int unsigned CW     = $clog2(DW_DEF + 1);

   // Iteration counter width for an arbitrary dividend width.
   function automatic int unsigned cnt_width(input int unsigned dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration; combinational so it can be reused in unrolled datapaths.
module seq_divider_div_step
   import seq_divider_pkg::*;
#(
   parameter int unsigned VW = VW_DEF
) (
   input  logic [VW:0]   r,
   input  logic          q_msb,
   input  logic [VW-1:0] d,
   output logic [VW:0]   r_next_c,
   output logic          q_bit_c
);

   logic [VW+1:0] shifted;
   logic [VW+1:0] dext;

   always_comb begin
      shifted = {r, q_msb};
      dext    = {2'b00, d};
      if (shifted >= dext) begin
         r_next_c = (VW+1)'(shifted - dext);
         q_bit_c  = 1'b1;
      end else begin
         r_next_c = shifted[VW:0];
         q_bit_c  = 1'b0;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// Results and div_zero hold until the next accepted start.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          busy,
   output logic          done,
   output logic          div_zero
);

   localparam int unsigned CWI = cnt_width(DW);

   div_state_t      state, state_n;
   logic [DW-1:0]   q, q_n;
   logic [VW:0]     r, r_n;
   logic [VW-1:0]   d, d_n;
   logic [CWI-1:0]  cnt, cnt_n;
   logic [DW-1:0]   quotient_n;
   logic [VW-1:0]   remainder_n;
   logic            busy_n, done_n, div_zero_n;
   logic [VW:0]     r_step;
   logic            q_bit;

   seq_divider_div_step #(.VW(VW)) u_step (
      .r        (r),
      .q_msb    (q[DW-1]),
      .d        (d),
      .r_next_c (r_step),
      .q_bit_c  (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         q         <= '0;
         r         <= '0;
         d         <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         state     <= state_n;
         q         <= q_n;
         r         <= r_n;
         d         <= d_n;
         cnt       <= cnt_n;
         quotient  <= quotient_n;
         remainder <= remainder_n;
         busy      <= busy_n;
         done      <= done_n;
         div_zero  <= div_zero_n;
      end
   end

   // Next-state and next-register logic; done is a single-cycle pulse by default.
   always_comb begin
      state_n     = state;
      q_n         = q;
      r_n         = r;
      d_n         = d;
      cnt_n       = cnt;
      quotient_n  = quotient;
      remainder_n = remainder;
      busy_n      = busy;
      done_n      = 1'b0;
      div_zero_n  = div_zero;

      case (state)
         IDLE: begin
            if (start) begin
               busy_n = 1'b1;
               if (divisor != '0) begin
                  q_n        = dividend;
                  r_n        = '0;
                  d_n        = divisor;
                  cnt_n      = CWI'(DW);
                  div_zero_n = 1'b0;
                  state_n    = CALC;
               end else begin
                  // Zero divisor skips iteration; FIN publishes the preloaded result.
                  q_n        = '1;
                  r_n        = {1'b0, dividend[VW-1:0]};
                  d_n        = '0;
                  cnt_n      = '0;
                  div_zero_n = 1'b1;
                  state_n    = FIN;
               end
            end
         end

         CALC: begin
            q_n   = {q[DW-2:0], q_bit};
            r_n   = r_step;
            cnt_n = cnt - CWI'(1);
            if (cnt == CWI'(1)) begin
               state_n = FIN;
            end
         end

         FIN: begin
            quotient_n  = q;
            remainder_n = r[VW-1:0];
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider using restoring shift-subtract. It is the inverse companion of the team's repeated-add multiplier.
- Takes a DW-bit dividend and a VW-bit divisor. Produces a DW-bit quotient and a VW-bit remainder after a fixed DW-cycle computation.
- Uses a start/busy/done handshake so a controller can issue back-to-back operations.
- Sits beside the multiplier in the arithmetic datapath. A product from the multiplier divided by one of its operands returns the other operand.

Parameters:
- DW, 16, dividend and quotient width (≥2).
- VW, 8, divisor and remainder width (≥1, ≤DW).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset.
- start  input  1  request pulse; sampled only while idle.
- dividend  input  DW  unsigned dividend; captured when start is accepted.
- divisor  input  VW  unsigned divisor; captured when start is accepted.
- quotient  output  DW  result quotient; registered.
- remainder  output  VW  result remainder; registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- div_zero  output  1  set with done when divisor was 0; held until next accepted start.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - Reset clears all state: quotient=0, remainder=0, busy=0, done=0, div_zero=0.
  - The FSM returns to IDLE. The internal counter and working registers are cleared.
- FSM states: IDLE, CALC, FIN.
- IDLE, start=1 with divisor≠0:
  - Capture the operands: working quotient q←dividend, partial remainder r←0 (VW+1 bits), divisor register d←divisor.
  - Set cnt←DW, busy←1, div_zero←0. Go to CALC.
- IDLE, start=1 with divisor=0:
  - Go to FIN directly with quotient←all ones, remainder←dividend[VW-1:0], div_zero←1, busy←1.
- CALC, each cycle:
  - Shift: r←{r[VW-1:0], q[DW-1]}, q←q<<1.
  - If the shifted r≥{0,d}, then r←r−d and q[0]←1. Otherwise q[0]←0.
  - cnt←cnt−1. When cnt reaches 1, go to FIN after this update.
  - Exactly DW CALC cycles per operation.
- FIN, single cycle:
  - Register quotient←q and remainder←r[VW-1:0]. The divide-by-zero path has already loaded these.
  - done←1 for this one cycle. busy←0 on exit. Return to IDLE.
- Latency:
  - Normal operation: start sampled at edge N; done high in cycle N+DW+1; results valid from that cycle.
  - Divide by zero: done high at cycle N+1.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on the next edge, because the FSM is in IDLE then. No dead cycle is required beyond FIN.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accepting edge.
- Output hold: quotient, remainder and div_zero hold their values until the next accepted start. A new start clears div_zero immediately; quotient and remainder update only at FIN.
- Arithmetic:
  - All values are unsigned.
  - The partial remainder is VW+1 bits so the compare/subtract never overflows.
  - The invariant dividend = quotient·divisor + remainder holds, with remainder < divisor.
- Reset asserted mid-CALC aborts immediately. No done pulse is issued and all outputs go to reset values.

Decomposition:
- Shared arithmetic package holds:
  - FSM state encoding: IDLE=2'd0, CALC=2'd1, FIN=2'd2.
  - Default width constants DW_DEF=16, VW_DEF=8.
  - Counter width constant CW=$clog2(DW+1).
- One natural sub-module: div_step. It is combinational and implements one restoring iteration: inputs r, q msb, d; outputs next r and quotient bit. Keeping it separate lets a future unrolled or pipelined divider reuse the same step.

Test Plan:
- dividend=1000, divisor=7, start pulse → done exactly 17 cycles after the start edge; quotient=142, remainder=6, div_zero=0; busy high for 17 cycles.
- dividend=16'hFFFF, divisor=1 → quotient=16'hFFFF, remainder=0; dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=1234 (16'h04D2), divisor=0 → done 1 cycle after start; div_zero=1, quotient=16'hFFFF, remainder=8'hD2.
- Multiplier inverse: dividend=200·131=26200, divisor=131 → quotient=200, remainder=0. Then start asserted in the done cycle with 26200/200 → second done 17 cycles later with quotient=131.
- start re-pulsed at cycle 5 of CALC with different operands → ignored; original result returned and no extra done pulse. Then rst_n driven low at cycle 8 of a new operation → all outputs 0 asynchronously and no done pulse; the next start after release computes correctly.
- Random sweep of 10k operand pairs with divisor≠0 → quotient·divisor+remainder==dividend and remainder<divisor on every done.
